// File: rtl/mod_cache_arbiter.sv
// rtl/mod_cache_arbiter.sv - arbitrates L1 icache/dcache block misses onto a single 64-bit bus
// Define ARB_FIXED_PRIO_EN for fixed dcache priority instead of round-robin.
module mod_cache_arbiter #(
    parameter int WORDSIZE = 64,
    parameter int LOGWIDTH = 6,
    parameter int TAGWIDTH = 13
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [WORDSIZE-1:0]         ic_req,
    input  logic [TAGWIDTH-1:0]         ic_reqtag,
    input  logic                        ic_reqcyc,
    output logic                        ic_reqack,
    output logic [(8<<LOGWIDTH)-1:0]    ic_resp,
    output logic [TAGWIDTH-1:0]         ic_resptag,
    output logic                        ic_respcyc,
    input  logic                        ic_respack,

    input  logic [WORDSIZE-1:0]         dc_req,
    input  logic [TAGWIDTH-1:0]         dc_reqtag,
    input  logic [(8<<LOGWIDTH)-1:0]    dc_wdata,
    input  logic                        dc_reqcyc,
    output logic                        dc_reqack,
    output logic [(8<<LOGWIDTH)-1:0]    dc_resp,
    output logic [TAGWIDTH-1:0]         dc_resptag,
    output logic                        dc_respcyc,
    input  logic                        dc_respack,

    output logic [WORDSIZE-1:0]         bus_req,
    output logic [TAGWIDTH-1:0]         bus_reqtag,
    output logic                        bus_reqcyc,
    input  logic                        bus_reqack,
    input  logic [WORDSIZE-1:0]         bus_resp,
    input  logic [TAGWIDTH-1:0]         bus_resptag,
    input  logic                        bus_respcyc,
    output logic                        bus_respack
);

    localparam int BLKW  = 8 << LOGWIDTH;
    localparam int BEATS = BLKW / WORDSIZE;
    localparam int CW    = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RDATA,
        DELIVER
    } state_t;

    state_t                             state;
    state_t                             state_nx;
    logic [WORDSIZE-1:0]                addr_q;
    logic [TAGWIDTH-1:0]                tag_q;
    logic [BEATS-1:0][WORDSIZE-1:0]     blk_q;
    logic [CW-1:0]                      cnt_q;
    logic                               owner_q;
    logic                               write_q;

    logic                               grant_ic;
    logic                               grant_dc;
    logic                               beat_last;
    logic                               beat_hit;

`ifdef ARB_FIXED_PRIO_EN
    assign grant_dc = dc_reqcyc;
    assign grant_ic = ic_reqcyc && !dc_reqcyc;
`else
    // rr_q = 1 favours the dcache on the next simultaneous request.
    logic                               rr_q;

    assign grant_dc = dc_reqcyc && (!ic_reqcyc || rr_q);
    assign grant_ic = ic_reqcyc && (!dc_reqcyc || !rr_q);
`endif

    assign beat_last   = (cnt_q == CW'(BEATS - 1));
    assign beat_hit    = bus_respcyc && (bus_resptag == tag_q);
    assign bus_respack = bus_respcyc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ic_reqack  = 1'b0;
        dc_reqack  = 1'b0;
        ic_respcyc = 1'b0;
        dc_respcyc = 1'b0;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        case (state)
            IDLE: begin
                if (ic_reqcyc || dc_reqcyc) begin
                    state_nx  = ADDR;
                    ic_reqack = grant_ic;
                    dc_reqack = grant_dc;
                end
            end
            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = addr_q;
                bus_reqtag = tag_q;
                if (bus_reqack) begin
                    state_nx = write_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = blk_q[cnt_q];
                bus_reqtag = tag_q;
                if (bus_reqack && beat_last) begin
                    state_nx = DELIVER;
                end
            end
            RDATA: begin
                if (beat_hit && beat_last) begin
                    state_nx = DELIVER;
                end
            end
            DELIVER: begin
                ic_respcyc = !owner_q;
                dc_respcyc = owner_q;
                if (owner_q ? dc_respack : ic_respack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // The grant is combinational from reqcyc, so it must be masked while reset is held.
        if (!reset) begin
            ic_reqack = 1'b0;
            dc_reqack = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            tag_q   <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            write_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ic_reqcyc || dc_reqcyc) begin
                        addr_q  <= grant_dc ? dc_req : ic_req;
                        tag_q   <= grant_dc ? dc_reqtag : ic_reqtag;
                        owner_q <= grant_dc;
                        // Only the dcache may write; an icache tag MSB still means read.
                        write_q <= grant_dc && dc_reqtag[TAGWIDTH-1];
                        cnt_q   <= '0;
                        if (grant_dc) begin
                            blk_q <= dc_wdata;
                        end
`ifndef ARB_FIXED_PRIO_EN
                        rr_q    <= grant_ic;
`endif
                    end
                end
                ADDR: begin
                    if (bus_reqack) begin
                        cnt_q <= '0;
                    end
                end
                WDATA: begin
                    if (bus_reqack) begin
                        if (beat_last) begin
                            cnt_q <= '0;
                            blk_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                RDATA: begin
                    if (beat_hit) begin
                        blk_q[cnt_q] <= bus_resp;
                        if (beat_last) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ic_resp    = (state == DELIVER && !owner_q) ? blk_q : '0;
    assign ic_resptag = (state == DELIVER && !owner_q) ? tag_q : '0;
    assign dc_resp    = (state == DELIVER &&  owner_q) ? blk_q : '0;
    assign dc_resptag = (state == DELIVER &&  owner_q) ? tag_q : '0;

endmodule

// File: tb/tb_mod_cache_arbiter.sv
// tb/tb_mod_cache_arbiter.sv - self-checking bench for mod_cache_arbiter
module tb_mod_cache_arbiter;

    logic           clk = 1'b0;
    logic           reset;
    logic [63:0]    ic_req;
    logic [12:0]    ic_reqtag;
    logic           ic_reqcyc;
    logic           ic_reqack;
    logic [511:0]   ic_resp;
    logic [12:0]    ic_resptag;
    logic           ic_respcyc;
    logic           ic_respack;
    logic [63:0]    dc_req;
    logic [12:0]    dc_reqtag;
    logic [511:0]   dc_wdata;
    logic           dc_reqcyc;
    logic           dc_reqack;
    logic [511:0]   dc_resp;
    logic [12:0]    dc_resptag;
    logic           dc_respcyc;
    logic           dc_respack;
    logic [63:0]    bus_req;
    logic [12:0]    bus_reqtag;
    logic           bus_reqcyc;
    logic           bus_reqack;
    logic [63:0]    bus_resp;
    logic [12:0]    bus_resptag;
    logic           bus_respcyc;
    logic           bus_respack;

    mod_cache_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_reqtag(ic_reqtag), .ic_reqcyc(ic_reqcyc), .ic_reqack(ic_reqack),
        .ic_resp(ic_resp), .ic_resptag(ic_resptag), .ic_respcyc(ic_respcyc), .ic_respack(ic_respack),
        .dc_req(dc_req), .dc_reqtag(dc_reqtag), .dc_wdata(dc_wdata), .dc_reqcyc(dc_reqcyc),
        .dc_reqack(dc_reqack), .dc_resp(dc_resp), .dc_resptag(dc_resptag), .dc_respcyc(dc_respcyc),
        .dc_respack(dc_respack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respcyc(bus_respcyc),
        .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           dc;
        logic [63:0]    addr;
        logic [12:0]    tag;
        logic [63:0]    base;
        int             stall_beat;
        int             stall_n;
        int             bad_at;
        int             ack_delay;
        int             rst_beat;
        logic           pend_next;
        logic           exp_write;
    } vec_t;

    typedef struct packed {
        logic           dc;
        logic [12:0]    tag;
        logic [511:0]   blk;
    } sb_t;

    vec_t   vecs[16];
    int     n_vec = 0;
    sb_t    sb_q[$];
    int     n_chk = 0;
    int     n_fail = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] words(input logic [63:0] base);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[k*64 +: 64] = base + 64'(k);
        return r;
    endfunction

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic add_vec(input logic dc, input logic [63:0] addr, input logic [12:0] tag,
                           input logic [63:0] base, input int sb, input int sn, input int bad,
                           input int dly, input int rb, input logic pn, input logic ew);
        vecs[n_vec].dc         = dc;
        vecs[n_vec].addr       = addr;
        vecs[n_vec].tag        = tag;
        vecs[n_vec].base       = base;
        vecs[n_vec].stall_beat = sb;
        vecs[n_vec].stall_n    = sn;
        vecs[n_vec].bad_at     = bad;
        vecs[n_vec].ack_delay  = dly;
        vecs[n_vec].rst_beat   = rb;
        vecs[n_vec].pend_next  = pn;
        vecs[n_vec].exp_write  = ew;
        n_vec++;
    endtask

    task automatic set_req(input int i);
        if (vecs[i].dc) begin
            dc_req    = vecs[i].addr;
            dc_reqtag = vecs[i].tag;
            dc_wdata  = words(vecs[i].base);
            dc_reqcyc = 1'b1;
        end else begin
            ic_req    = vecs[i].addr;
            ic_reqtag = vecs[i].tag;
            ic_reqcyc = 1'b1;
        end
    endtask

    task automatic serve(input int i, output int wait_n);
        vec_t           v;
        sb_t            e;
        logic [511:0]   w;
        int             k;
        bit             bad_done;
        v = vecs[i];
        w = words(v.base);
        #1;
        wait_n = 0;
        while (!(ic_reqack || dc_reqack) && wait_n < 40) begin
            step;
            wait_n++;
        end
        chk("ack_seen", 512'(ic_reqack | dc_reqack), 512'(1'b1));
        chk("grant_ic", 512'(ic_reqack), 512'(!v.dc));
        chk("grant_dc", 512'(dc_reqack), 512'(v.dc));
        e.dc  = v.dc;
        e.tag = v.tag;
        e.blk = v.exp_write ? 512'd0 : w;
        sb_q.push_back(e);
        step;
        chk("addr_reqcyc", 512'(bus_reqcyc), 512'(1'b1));
        chk("addr_req", 512'(bus_req), 512'(v.addr));
        chk("addr_tag", 512'(bus_reqtag), 512'(v.tag));
        chk("addr_noack", 512'(ic_reqack | dc_reqack), 512'(1'b0));
        bus_reqack = 1'b1;
        if (v.dc) begin
            dc_reqcyc = 1'b0;
            dc_wdata  = ~w;
        end else begin
            ic_reqcyc = 1'b0;
        end
        if (v.pend_next) set_req(i + 1);
        step;
        if (v.exp_write) begin
            for (k = 0; k < 8; k++) begin
                int left;
                left = (k == v.stall_beat) ? v.stall_n : 0;
                for (int s = 0; s <= left; s++) begin
                    chk("wr_reqcyc", 512'(bus_reqcyc), 512'(1'b1));
                    chk("wr_beat", 512'(bus_req), 512'(w[k*64 +: 64]));
                    if (k == v.rst_beat) begin
                        reset      = 1'b0;
                        bus_reqack = 1'b0;
                        #1;
                        chk("rst_reqcyc", 512'(bus_reqcyc), 512'(1'b0));
                        chk("rst_req", 512'(bus_req), 512'd0);
                        chk("rst_respcyc", 512'({ic_respcyc, dc_respcyc}), 512'd0);
                        chk("rst_reqack", 512'({ic_reqack, dc_reqack}), 512'd0);
                        chk("rst_dc_resp", dc_resp, 512'd0);
                        void'(sb_q.pop_back());
                        step;
                        step;
                        chk("rst_no_resp", 512'({ic_respcyc, dc_respcyc, bus_reqcyc}), 512'd0);
                        reset = 1'b1;
                        step;
                        return;
                    end
                    bus_reqack = (s == left);
                    step;
                end
            end
            bus_reqack = 1'b0;
            chk("wr_done_reqcyc", 512'(bus_reqcyc), 512'(1'b0));
        end else begin
            chk("rd_reqcyc_low", 512'(bus_reqcyc), 512'(1'b0));
            bus_reqack = 1'b0;
            k = 0;
            bad_done = 1'b0;
            while (k < 8) begin
                if (k == v.bad_at && !bad_done) begin
                    bus_resp    = 64'hBAD0_BAD0_BAD0_BAD0;
                    bus_resptag = 13'h007;
                    bus_respcyc = 1'b1;
                    #1;
                    chk("bad_respack", 512'(bus_respack), 512'(1'b1));
                    bad_done = 1'b1;
                end else begin
                    bus_resp    = v.base + 64'(k);
                    bus_resptag = v.tag;
                    bus_respcyc = 1'b1;
                    k++;
                end
                step;
            end
            bus_respcyc = 1'b0;
        end
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 512'd0, 512'd1);
        end else begin
            e = sb_q.pop_front();
            for (int d = 0; d <= v.ack_delay; d++) begin
                if (d > 0) step;
                chk("resp_cyc", 512'(e.dc ? dc_respcyc : ic_respcyc), 512'(1'b1));
                chk("resp_other", 512'(e.dc ? ic_respcyc : dc_respcyc), 512'(1'b0));
                chk("resp_data", e.dc ? dc_resp : ic_resp, e.blk);
                chk("resp_tag", 512'(e.dc ? dc_resptag : ic_resptag), 512'(e.tag));
                chk("busy_noack", 512'(ic_reqack | dc_reqack), 512'(1'b0));
            end
            if (e.dc) dc_respack = 1'b1;
            else      ic_respack = 1'b1;
            step;
            ic_respack = 1'b0;
            dc_respack = 1'b0;
            chk("resp_drop", 512'({ic_respcyc, dc_respcyc}), 512'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, simulation still running");
        $fatal(1);
    end

    initial begin
        int w;
        int first;
        int second;
        reset = 1'b0;
        ic_req = '0; ic_reqtag = '0; ic_reqcyc = 1'b0; ic_respack = 1'b0;
        dc_req = '0; dc_reqtag = '0; dc_wdata = '0; dc_reqcyc = 1'b0; dc_respack = 1'b0;
        bus_reqack = 1'b0; bus_resp = '0; bus_resptag = '0; bus_respcyc = 1'b0;
        step;
        ic_reqcyc = 1'b1;
        dc_reqcyc = 1'b1;
        step;
        chk("reset_reqack", 512'({ic_reqack, dc_reqack}), 512'd0);
        chk("reset_respcyc", 512'({ic_respcyc, dc_respcyc}), 512'd0);
        chk("reset_bus_reqcyc", 512'(bus_reqcyc), 512'(1'b0));
        chk("reset_bus_req", 512'(bus_req), 512'd0);
        chk("reset_ic_resp", ic_resp, 512'd0);
        chk("reset_dc_resp", dc_resp, 512'd0);
        ic_reqcyc = 1'b0;
        dc_reqcyc = 1'b0;
        reset = 1'b1;
        step;

        //      dc    addr         tag       base                stb sn bad dly rst pn ew
        add_vec(1'b0, 64'h1000, 13'h0005, 64'h0,               -1, 0, -1, 3, -1, 1'b0, 1'b0);
        add_vec(1'b1, 64'h2040, 13'h1003, 64'hA0,               3, 2, -1, 0, -1, 1'b0, 1'b1);
        add_vec(1'b0, 64'h3000, 13'h0005, 64'h0,               -1, 0,  3, 1, -1, 1'b0, 1'b0);
        add_vec(1'b1, 64'h4000, 13'h0021, 64'h100,             -1, 0, -1, 0, -1, 1'b0, 1'b0);
        add_vec(1'b0, 64'h5000, 13'h1011, 64'h200,             -1, 0, -1, 0, -1, 1'b0, 1'b0);
        add_vec(1'b0, 64'h6000, 13'h0042, 64'h300,             -1, 0, -1, 5, -1, 1'b1, 1'b0);
        add_vec(1'b1, 64'h7000, 13'h1ABC, 64'hDEAD0000,         0, 1, -1, 2, -1, 1'b0, 1'b1);
        add_vec(1'b1, 64'h8000, 13'h1004, 64'hB0,              -1, 0, -1, 0,  4, 1'b0, 1'b1);
        add_vec(1'b0, 64'h1000, 13'h0005, 64'h0,               -1, 0, -1, 0, -1, 1'b0, 1'b0);
        add_vec(1'b1, 64'h9000, 13'h0055, 64'h400,             -1, 0, -1, 0, -1, 1'b0, 1'b0);
        add_vec(1'b0, 64'hA000, 13'h0061, 64'h500,             -1, 0, -1, 0, -1, 1'b0, 1'b0);
        add_vec(1'b1, 64'hB000, 13'h1062, 64'h600,             -1, 0, -1, 1, -1, 1'b0, 1'b1);
        add_vec(1'b0, 64'hC000, 13'h0063, 64'h700,             -1, 0, -1, 0, -1, 1'b0, 1'b0);
        add_vec(1'b1, 64'hD000, 13'h0064, 64'h800,             -1, 0, -1, 0, -1, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            if (!(i > 0 && vecs[i-1].pend_next)) set_req(i);
            serve(i, w);
            if (i > 0 && vecs[i-1].pend_next) chk("turnaround_wait", 512'(w), 512'd0);
        end

        // Simultaneous requests: winner, then the held loser, then both again.
`ifdef ARB_FIXED_PRIO_EN
        first  = 11;
        second = 10;
`else
        first  = 10;
        second = 11;
`endif
        set_req(10);
        set_req(11);
        serve(first, w);
        serve(second, w);
        chk("arb_loser_wait", 512'(w), 512'd0);
        set_req(12);
        set_req(13);
        serve(first + 2, w);
        serve(second + 2, w);
        chk("arb_loser_wait2", 512'(w), 512'd0);
        chk("sb_drained", 512'(sb_q.size()), 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_cache_arbiter.md
Name: mod_cache_arbiter

Overview:
- Sits directly downstream of the L1 instruction and data caches.
- Arbitrates their block-miss traffic onto the single 64-bit system bus.
- Serialises 512-bit dcache writebacks into 8 data beats, and assembles 8 read response beats into one 512-bit block per requester.
- One transaction is outstanding at a time.

Parameters:
WORDSIZE, 64, bus beat width in bits
LOGWIDTH, 6, log2 of block size in bytes (64 B block, 512 bits)
TAGWIDTH, 13, request/response tag width; tag bit [TAGWIDTH-1] = 1 marks a write
BEATS, (1<<LOGWIDTH)*8/WORDSIZE = 8, beats per block (derived, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
ic_req  in  64  icache miss address (block aligned)
ic_reqtag  in  TAGWIDTH  icache tag (always read)
ic_reqcyc  in  1  icache request valid
ic_reqack  out  1  one-cycle pulse when icache request accepted
ic_resp  out  512  assembled block to icache
ic_resptag  out  TAGWIDTH  echoed icache tag
ic_respcyc  out  1  icache response valid
ic_respack  in  1  icache accepts response
dc_req  in  64  dcache address
dc_reqtag  in  TAGWIDTH  dcache tag; MSB = 1 for writeback
dc_wdata  in  512  writeback block, sampled when dc_reqack pulses
dc_reqcyc, dc_reqack, dc_resp(512), dc_resptag, dc_respcyc, dc_respack  as icache equivalents
bus_req  out  64  address beat, then write data beats
bus_reqtag  out  TAGWIDTH  tag of current transaction
bus_reqcyc  out  1  bus request beat valid
bus_reqack  in  1  bus accepted current beat
bus_resp  in  64  read response beat
bus_resptag  in  TAGWIDTH  response tag
bus_respcyc  in  1  response beat valid
bus_respack  out  1  equals bus_respcyc combinationally

Behaviour:
- Reset (async, reset==0): state=IDLE. All reqack/respcyc/reqcyc outputs 0. ic_resp, dc_resp and bus_req are 0. Beat counter is 0. Round-robin pointer is 0 (icache favoured first).
- A reset mid-transaction abandons that transaction. No client response is generated.
- States: IDLE, ADDR, WDATA, RDATA, DELIVER.
- IDLE:
  - One requester pending: grant it.
  - Both pending: grant the one the pointer selects; after each grant the pointer flips to the other client.
  - On grant: latch address, tag and (dc only) wdata. Pulse the winner's reqack for exactly 1 cycle. Go to ADDR next cycle.
- ADDR: bus_reqcyc=1, bus_req=address, bus_reqtag=tag. These are held stable until bus_reqack=1 at a clock edge. Then go to WDATA if tag MSB=1, else RDATA. Counter is cleared.
- WDATA:
  - Beat k drives bus_req = wdata[64k+63:64k], k = 0..7, ascending.
  - Each beat is held until bus_reqack. bus_reqcyc stays 1 between beats with no bubble.
  - After beat 7 is acked: bus_reqcyc=0, go to DELIVER with resp=0 (write acknowledgement).
- RDATA:
  - bus_reqcyc=0.
  - Each cycle with bus_respcyc=1 and bus_resptag==latched tag: store beat into block[64k+63:64k], k++.
  - A beat with a mismatched tag is acked and discarded; k is unchanged.
  - After beat 7 is stored, go to DELIVER.
- DELIVER:
  - The granted client's respcyc=1, with resp=block and resptag=latched tag.
  - Held until that client's respack=1 at an edge. Then respcyc=0 and state returns to IDLE.
  - Minimum turnaround: DELIVER to the next grant takes 1 cycle (IDLE).
- Requests arriving while busy are not acked; the client holds reqcyc.
- A reqcyc deasserted before its reqack pulse is a protocol violation. Behaviour is undefined.
- An icache tag MSB of 1 is treated as a read; icache writes are illegal.
- Minimum read latency: grant edge to client respcyc = 1 (ADDR) + bus ack + 8 beat cycles + 1.
- The counter is 3 bits and wraps only via state exit, never modulo.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, dcache always wins simultaneous requests. The round-robin pointer is removed.
- Undefined: round-robin as above.
- Single-requester behaviour is identical either way.

Test Plan:
- icache read, addr 0x1000, tag 0x005. Bus acks in the cycle after ADDR entry, then returns beats 0x0..0x7 with tag 0x005 → ic_respcyc=1, ic_resp word k = k, ic_resptag=0x005. Held until ic_respack.
- dcache writeback, tag 0x1003, wdata words 0xA0..0xA7 → bus sees address 0x2040, then 0xA0..0xA7 in order. bus_reqack is stalled 2 cycles on beat 3; beat 3 must be held unchanged. dc_respcyc=1 with dc_resp=0.
- ic and dc reqcyc rise in the same cycle, three times in succession (round-robin build) → grant order ic, dc, ic. With ARB_FIXED_PRIO_EN: dc, ic, dc.
- During icache read, inject a response beat with tag 0x007 between beats 2 and 3 → beat is dropped (bus_respack=1 that cycle). Final block is words 0..7 with no corruption.
- reset driven 0 midway through WDATA beat 4 → all outputs 0 asynchronously, before the next edge. After release, a new icache read completes normally.
- Client withholds respack for 5 cycles → respcyc and resp stay stable. The other client's pending request is not acked until 1 cycle after respack.
